// File: rtl/rx_pkt_commit_fifo_pkg.sv
// Shared definitions for the RX packet commit FIFO.
// Word flag positions and write-side FSM encodings.
package rx_pkt_commit_fifo_pkg;

  localparam int DW      = 36;
  localparam int SOF_BIT = 32;
  localparam int EOF_BIT = 33;
  localparam int OCC_LSB = 34;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_WRITE = 2'd1,
    ST_DROP  = 2'd2
  } wr_state_e;

  function automatic logic [15:0] sat_inc(
    input logic [15:0] v
  );
    return (v == 16'hFFFF) ? v : v + 16'd1;
  endfunction

endpackage

// File: rtl/ram_2port.sv
// Simple dual-port RAM, one write port, one read port.
// Read data is registered and held while re is low.
module ram_2port #(
  parameter int DWIDTH = 36,
  parameter int AWIDTH = 9
) (
  input  logic              clk,
  input  logic              we,
  input  logic [AWIDTH-1:0] waddr,
  input  logic [DWIDTH-1:0] wdata,
  input  logic              re,
  input  logic [AWIDTH-1:0] raddr,
  output logic [DWIDTH-1:0] rdata
);

  logic [DWIDTH-1:0] mem [2**AWIDTH];

  // Storage write and registered read.
  always_ff @(posedge clk) begin
    if (we) mem[waddr] <= wdata;
    if (re) rdata <= mem[raddr];
  end

endmodule

// File: rtl/rx_pkt_commit_fifo.sv
// Store-and-forward packet FIFO between the RX VITA chain and
// the router; a packet becomes visible only after its EOF lands.
module rx_pkt_commit_fifo
  import rx_pkt_commit_fifo_pkg::*;
#(
  parameter int SIZE           = 9,
  parameter bit DROP_WHEN_FULL = 1'b1
) (
  input  logic            clk,
  input  logic            reset,
  input  logic            clear,
  input  logic [35:0]     data_i,
  input  logic            src_rdy_i,
  output logic            dst_rdy_o,
  output logic [35:0]     data_o,
  output logic            src_rdy_o,
  input  logic            dst_rdy_i,
  output logic [SIZE:0]   occupied,
  output logic [15:0]     pkt_count,
  output logic [15:0]     drop_count
);

  localparam int PW = SIZE + 1;
  localparam logic [PW-1:0] DEPTH = {1'b1, {SIZE{1'b0}}};
  localparam logic [PW-1:0] ONE   = PW'(1);

  wr_state_e st_q, st_d;

  logic [PW-1:0] wr_q, wr_d;
  logic [PW-1:0] cm_q, cm_d;
  logic [PW-1:0] rd_q, rd_d;
  logic [PW-1:0] fp_q, fp_d;
  logic [15:0]   pkt_q, pkt_d;
  logic [15:0]   drop_q, drop_d;
  logic          rv_q, rv_d;
  logic          ov_q, ov_d;
  logic [35:0]   out_q, out_d;

  logic          full;
  logic          stall_dl;
  logic          in_xfer;
  logic          out_xfer;
  logic          sof;
  logic          eof;
  logic          commit_pkt;
  logic          load_out;
  logic          eof_rd;

  logic          ram_we;
  logic [SIZE-1:0] ram_waddr;
  logic          ram_re;
  logic [35:0]   ram_rdata;

  assign full = (wr_q - rd_q) == DEPTH;
  // A packet longer than the buffer with nothing to drain would
  // otherwise wait forever, so it is accepted and dropped.
  assign stall_dl = (st_q == ST_WRITE) && (cm_q == rd_q);

  assign dst_rdy_o = !reset && !clear &&
                     (DROP_WHEN_FULL || !full || stall_dl);

  assign in_xfer  = src_rdy_i && dst_rdy_o;
  assign out_xfer = ov_q && dst_rdy_i && !reset && !clear;
  assign sof      = data_i[SOF_BIT];
  assign eof      = data_i[EOF_BIT];

  // Write FSM: speculative store, commit on EOF, rewind on error.
  always_comb begin
    st_d       = st_q;
    wr_d       = wr_q;
    cm_d       = cm_q;
    drop_d     = drop_q;
    ram_we     = 1'b0;
    ram_waddr  = wr_q[SIZE-1:0];
    commit_pkt = 1'b0;
    if (in_xfer) begin
      unique case (st_q)
        ST_IDLE: begin
          if (!sof) begin
            drop_d = sat_inc(drop_q);
          end else if (full) begin
            drop_d = sat_inc(drop_q);
            st_d   = eof ? ST_IDLE : ST_DROP;
          end else begin
            ram_we = 1'b1;
            wr_d   = wr_q + ONE;
            if (eof) begin
              cm_d       = wr_q + ONE;
              commit_pkt = 1'b1;
            end else begin
              st_d = ST_WRITE;
            end
          end
        end
        ST_WRITE: begin
          if (sof) begin
            drop_d    = sat_inc(drop_q);
            ram_we    = 1'b1;
            ram_waddr = cm_q[SIZE-1:0];
            wr_d      = cm_q + ONE;
            if (eof) begin
              cm_d       = cm_q + ONE;
              commit_pkt = 1'b1;
              st_d       = ST_IDLE;
            end
          end else if (full) begin
            drop_d = sat_inc(drop_q);
            wr_d   = cm_q;
            st_d   = eof ? ST_IDLE : ST_DROP;
          end else begin
            ram_we = 1'b1;
            wr_d   = wr_q + ONE;
            if (eof) begin
              cm_d       = wr_q + ONE;
              commit_pkt = 1'b1;
              st_d       = ST_IDLE;
            end
          end
        end
        ST_DROP: begin
          if (eof) st_d = ST_IDLE;
        end
        default: st_d = ST_IDLE;
      endcase
    end
  end

  // Read side: fetch committed words into the RAM output stage,
  // then into the output register as soon as it frees up.
  always_comb begin
    load_out = rv_q && (!ov_q || out_xfer);
    ram_re   = (fp_q != cm_q) && (!rv_q || load_out);
    fp_d     = fp_q + PW'(ram_re);
    rv_d     = ram_re || (rv_q && !load_out);
    ov_d     = load_out || (ov_q && !out_xfer);
    out_d    = load_out ? ram_rdata : out_q;
    rd_d     = rd_q + PW'(out_xfer);
    eof_rd   = out_xfer && out_q[EOF_BIT];
    pkt_d    = pkt_q;
    unique case ({commit_pkt, eof_rd})
      2'b10:   pkt_d = pkt_q + 16'd1;
      2'b01:   pkt_d = pkt_q - 16'd1;
      default: pkt_d = pkt_q;
    endcase
  end

  // State update; clear flushes everything but the drop counter.
  always_ff @(posedge clk) begin
    if (reset || clear) begin
      st_q  <= ST_IDLE;
      wr_q  <= '0;
      cm_q  <= '0;
      rd_q  <= '0;
      fp_q  <= '0;
      rv_q  <= 1'b0;
      ov_q  <= 1'b0;
      out_q <= '0;
      pkt_q <= '0;
      if (reset) drop_q <= '0;
    end else begin
      st_q   <= st_d;
      wr_q   <= wr_d;
      cm_q   <= cm_d;
      rd_q   <= rd_d;
      fp_q   <= fp_d;
      rv_q   <= rv_d;
      ov_q   <= ov_d;
      out_q  <= out_d;
      pkt_q  <= pkt_d;
      drop_q <= drop_d;
    end
  end

  ram_2port #(
    .DWIDTH(36),
    .AWIDTH(SIZE)
  ) u_ram (
    .clk  (clk),
    .we   (ram_we),
    .waddr(ram_waddr),
    .wdata(data_i),
    .re   (ram_re),
    .raddr(fp_q[SIZE-1:0]),
    .rdata(ram_rdata)
  );

  assign data_o     = out_q;
  assign src_rdy_o  = ov_q;
  assign occupied   = cm_q - rd_q;
  assign pkt_count  = pkt_q;
  assign drop_count = drop_q;

endmodule
